// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: stall/flush enables, E-stage forwarding selects, memory-wait FSM with timeout.
// Outputs are combinational (zero latency); a data-memory wait freezes F/D/E/M and bubbles W until ready.
module hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64,
  parameter int TIMEOUT_EN  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       RS1_D,
  input  logic [4:0]       RS2_D,
  input  logic [4:0]       RS1_E,
  input  logic [4:0]       RS2_E,
  input  logic [4:0]       RD_E,
  input  logic             RegWriteE,
  input  logic             ResultSrcE,
  input  logic             PCSrcE,
  input  logic [4:0]       RD_M,
  input  logic             RegWriteM,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  input  logic [4:0]       RD_W,
  input  logic             RegWriteW,
  input  logic             clr_cnt,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  state_t        state, stateNext;
  logic [WW-1:0] waitCnt, waitCntNext;
  logic          timeoutSet;
  logic          memWait;
  logic          loadUse;
  logic          branchFlush;

  assign memWait = MemReqM & ~MemReadyM;
  assign loadUse = ResultSrcE & RegWriteE & (RD_E != 5'd0) &
                   ((RD_E == RS1_D) | (RD_E == RS2_D));

  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    timeoutSet  = 1'b0;
    case (state)
      RUN: begin
        if (memWait) begin
          stateNext   = MEM_WAIT;
          waitCntNext = WW'(1);
        end
      end
      MEM_WAIT: begin
        if (MemReadyM) begin
          stateNext   = RUN;
          waitCntNext = '0;
        end else if ((TIMEOUT_EN != 0) && (waitCnt == WW'(MEM_TIMEOUT - 1))) begin
          stateNext  = ERROR;
          timeoutSet = 1'b1;
        end else begin
          waitCntNext = waitCnt + WW'(1);
        end
      end
      ERROR:   stateNext = ERROR;
      default: stateNext = RUN;
    endcase
  end

  // Memory stall outranks the branch: the taken branch sits frozen in E and is honoured once memory is ready.
  always_comb begin
    StallF      = 1'b0;
    StallD      = 1'b0;
    StallE      = 1'b0;
    StallM      = 1'b0;
    FlushD      = 1'b0;
    FlushE      = 1'b0;
    FlushW      = 1'b0;
    branchFlush = 1'b0;
    if (rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else if ((state == ERROR) || memWait) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      FlushD      = 1'b1;
      FlushE      = 1'b1;
      branchFlush = 1'b1;
    end else if (loadUse) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (!rst) begin
      if (RegWriteM && (RD_M != 5'd0) && (RD_M == RS1_E))      ForwardAE = 2'b10;
      else if (RegWriteW && (RD_W != 5'd0) && (RD_W == RS1_E)) ForwardAE = 2'b01;
      if (RegWriteM && (RD_M != 5'd0) && (RD_M == RS2_E))      ForwardBE = 2'b10;
      else if (RegWriteW && (RD_W != 5'd0) && (RD_W == RS2_E)) ForwardBE = 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      waitCnt     <= '0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
      if (timeoutSet) mem_timeout <= 1'b1;
      if (clr_cnt) begin
        stall_cnt <= '0;
        flush_cnt <= '0;
      end else begin
        if (StallF && (stall_cnt != '1))      stall_cnt <= stall_cnt + CNT_W'(1);
        if (branchFlush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl, built with CNT_W=3 and MEM_TIMEOUT=4 to reach saturation and timeout quickly.
module tb_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W;
  logic       RegWriteE, ResultSrcE, PCSrcE, RegWriteM, MemReqM, MemReadyM, RegWriteW, clr_cnt;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_timeout;
  logic [1:0] ForwardAE, ForwardBE;
  logic [2:0] stall_cnt, flush_cnt;

  int vecCnt = 0;
  int errCnt = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(3), .MEM_TIMEOUT(4), .TIMEOUT_EN(1)) dut (
    .clk(clk), .rst(rst),
    .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .RD_M(RD_M), .RegWriteM(RegWriteM), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .RD_W(RD_W), .RegWriteW(RegWriteW), .clr_cnt(clr_cnt),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearIns();
    RS1_D = 0; RS2_D = 0; RS1_E = 0; RS2_E = 0; RD_E = 0; RD_M = 0; RD_W = 0;
    RegWriteE = 0; ResultSrcE = 0; PCSrcE = 0; RegWriteM = 0;
    MemReqM = 0; MemReadyM = 0; RegWriteW = 0; clr_cnt = 0;
  endtask

  function automatic logic [3:0] stalls();
    return {StallF, StallD, StallE, StallM};
  endfunction

  function automatic logic [2:0] flushes();
    return {FlushD, FlushE, FlushW};
  endfunction

  initial begin
    clearIns();
    rst = 1'b1;
    #1;
    chk("rst_stall", stalls(), 4'b0000);
    chk("rst_flush", flushes(), 3'b111);
    // Forwarding is forced off during reset even when a match exists.
    RD_M = 5'd3; RegWriteM = 1; RS1_E = 5'd3;
    #1;
    chk("rst_fwdA", ForwardAE, 2'b00);
    clearIns();
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_stallcnt", stall_cnt, 3'd0);
    chk("rst_flushcnt", flush_cnt, 3'd0);
    chk("rst_timeout", mem_timeout, 1'b0);
    chk("idle_flush", flushes(), 3'b000);

    // Load x5 in E, D reads x5 as rs2: one bubble.
    RD_E = 5'd5; RegWriteE = 1; ResultSrcE = 1; RS1_D = 5'd3; RS2_D = 5'd5;
    #1;
    chk("lu_stall", stalls(), 4'b1100);
    chk("lu_flush", flushes(), 3'b010);
    tick();
    clearIns();
    RS2_E = 5'd5; RS1_E = 5'd3; RD_M = 5'd5; RegWriteM = 1;
    #1;
    chk("lu_fwdB", ForwardBE, 2'b10);
    chk("lu_fwdA", ForwardAE, 2'b00);
    chk("lu_after_stall", stalls(), 4'b0000);
    chk("lu_stallcnt", stall_cnt, 3'd1);

    // Load to x0 never triggers a load-use stall.
    clearIns();
    RD_E = 5'd0; RegWriteE = 1; ResultSrcE = 1; RS1_D = 5'd0;
    #1;
    chk("lu_x0", stalls(), 4'b0000);

    // Taken branch beats a concurrent load-use.
    clearIns();
    PCSrcE = 1; RD_E = 5'd5; RegWriteE = 1; ResultSrcE = 1; RS1_D = 5'd5;
    #1;
    chk("br_flush", flushes(), 3'b110);
    chk("br_stall", stalls(), 4'b0000);
    tick();
    chk("br_flushcnt", flush_cnt, 3'd1);
    chk("br_stallcnt", stall_cnt, 3'd1);

    // Forwarding priority and x0 exclusion.
    clearIns();
    RD_M = 5'd7; RD_W = 5'd7; RS1_E = 5'd7; RS2_E = 5'd9; RegWriteM = 1; RegWriteW = 1;
    #1;
    chk("fwd_m_over_w", ForwardAE, 2'b10);
    chk("fwd_B_none", ForwardBE, 2'b00);
    RegWriteM = 0;
    #1;
    chk("fwd_w", ForwardAE, 2'b01);
    RD_W = 5'd9;
    #1;
    chk("fwd_B_w", ForwardBE, 2'b01);
    RegWriteM = 1; RD_M = 0; RD_W = 0; RS1_E = 0; RS2_E = 0;
    #1;
    chk("fwd_x0_A", ForwardAE, 2'b00);
    chk("fwd_x0_B", ForwardBE, 2'b00);

    // Memory wait of 3 cycles with a branch pending; ready lands when wait count reaches MEM_TIMEOUT-1.
    clearIns();
    MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mw_stall", stalls(), 4'b1111);
      chk("mw_flush", flushes(), 3'b001);
      tick();
    end
    MemReadyM = 1;
    #1;
    chk("mw_ready_stall", stalls(), 4'b0000);
    chk("mw_ready_flush", flushes(), 3'b110);
    tick();
    clearIns();
    #1;
    chk("mw_no_timeout", mem_timeout, 1'b0);
    chk("mw_stallcnt", stall_cnt, 3'd4);
    chk("mw_flushcnt", flush_cnt, 3'd2);
    chk("mw_run", stalls(), 4'b0000);

    // Memory never ready: timeout after 4 wait cycles, stalls persist.
    MemReqM = 1; MemReadyM = 0;
    for (int i = 0; i < 4; i++) begin
      chk("to_pending", mem_timeout, 1'b0);
      tick();
    end
    chk("to_set", mem_timeout, 1'b1);
    MemReqM = 0;
    #1;
    chk("to_err_stall", stalls(), 4'b1111);
    chk("to_err_flush", flushes(), 3'b001);
    tick();
    chk("to_sat_stallcnt", stall_cnt, 3'd7);
    chk("to_sticky", mem_timeout, 1'b1);
    rst = 1;
    #1;
    chk("to_rst_stall", stalls(), 4'b0000);
    tick();
    rst = 0;
    #1;
    chk("to_rst_timeout", mem_timeout, 1'b0);
    chk("to_rst_run", stalls(), 4'b0000);
    chk("to_rst_cnt", stall_cnt, 3'd0);

    // Saturation then clear while still stalling.
    RD_E = 5'd4; RegWriteE = 1; ResultSrcE = 1; RS1_D = 5'd4;
    for (int i = 0; i < 10; i++) tick();
    chk("sat_stallcnt", stall_cnt, 3'd7);
    chk("sat_flushcnt", flush_cnt, 3'd0);
    clr_cnt = 1;
    tick();
    chk("clr_wins", stall_cnt, 3'd0);
    clr_cnt = 0;
    tick();
    chk("clr_resume", stall_cnt, 3'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: bench did not complete, expected completion before 20000");
    $fatal(1);
  end
endmodule
